// File: rtl/proc_pkg.sv
// Shared processor definitions: datapath width, GPR count,
// MIR enable-field layout and the GPR update-op selector.
package proc_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int GPR_NUM    = 8;

  // MIR enable fields, each GPR_NUM bits wide
  localparam int MIR_LOAD_LSB = 0;
  localparam int MIR_CLR_LSB  = GPR_NUM;
  localparam int MIR_INC_LSB  = 2 * GPR_NUM;
  localparam int MIR_GPR_W    = 3 * GPR_NUM;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_INC  = 2'd1,
    OP_LOAD = 2'd2,
    OP_CLR  = 2'd3
  } gpr_op_e;

  function automatic gpr_op_e gpr_op(
    input logic clr,
    input logic load,
    input logic inc
  );
    if (clr)       return OP_CLR;
    else if (load) return OP_LOAD;
    else if (inc)  return OP_INC;
    else           return OP_HOLD;
  endfunction

endpackage

// File: rtl/gpr_cell.sv
// One general-purpose register with clr > load > inc
// priority and a sticky increment-overflow bit.
module gpr_cell
  import proc_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter bit INC_WRAP = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] d,
  input  logic              clr,
  input  logic              load,
  input  logic              inc,
  output logic [DATA_W-1:0] q,
  output logic              ovf
);

  gpr_op_e op;

  always_comb begin
    op = gpr_op(clr, load, inc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      ovf <= 1'b0;
    end else begin
      unique case (op)
        OP_CLR: begin
          q   <= '0;
          ovf <= 1'b0;
        end
        OP_LOAD: begin
          q   <= d;
          ovf <= 1'b0;
        end
        OP_INC: begin
          if (&q) begin
            // saturate keeps all-ones, wrap rolls to 0
            if (INC_WRAP) q <= '0;
            ovf <= 1'b1;
          end else begin
            q <= q + 1'b1;
          end
        end
        OP_HOLD: ;
      endcase
    end
  end

endmodule

// File: rtl/gpr_bank.sv
// Bank of general-purpose registers: C-bus writes under MIR
// control, combinational B-bus read mux and zero flags.
module gpr_bank
  import proc_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = GPR_NUM,
  parameter bit INC_WRAP = 1'b1,
  localparam int SEL_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   c_bus,
  input  logic [NUM_REGS-1:0] load,
  input  logic [NUM_REGS-1:0] clr,
  input  logic [NUM_REGS-1:0] inc,
  input  logic [SEL_W-1:0]    b_sel,
  output logic [DATA_W-1:0]   b_bus,
  output logic [NUM_REGS-1:0] zero,
  output logic [NUM_REGS-1:0] ovf
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
    gpr_cell #(
      .DATA_W   (DATA_W),
      .INC_WRAP (INC_WRAP)
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (c_bus),
      .clr   (clr[i]),
      .load  (load[i]),
      .inc   (inc[i]),
      .q     (regs[i]),
      .ovf   (ovf[i])
    );

    assign zero[i] = (regs[i] == '0);
  end

  // unmatched selects (non-power-of-2 depth) read as 0
  always_comb begin
    b_bus = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (b_sel == SEL_W'(i)) b_bus = regs[i];
    end
  end

endmodule
